// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: four-slot TDM receiver; locks to in_sync and presents whole frames on out_a..out_d.
module tdm_demux_1x4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sync,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             out_valid,
   output logic             sync_err,
   output logic             locked,
   output logic [1:0]       slot
);
   typedef enum logic {HUNT, LOCKED} state_t;
   state_t state, state_n;
   logic [1:0] slot_n;
   logic [WIDTH-1:0] h0, h1, h2;
   logic ld0, ldk, fire, err_n;
   always_comb begin
      state_n = state;
      slot_n = slot;
      ld0 = 1'b0;
      ldk = 1'b0;
      fire = 1'b0;
      err_n = 1'b0;
      if (in_valid) begin
         if (state == HUNT) begin
            ld0 = in_sync;
            slot_n = in_sync ? 2'd1 : 2'd0;
            state_n = in_sync ? LOCKED : HUNT;
         end else if (in_sync) begin
            ld0 = 1'b1;
            slot_n = 2'd1;
            err_n = slot != 2'd0;
         end else if (slot == 2'd0) begin
            err_n = 1'b1;
            state_n = HUNT;
         end else begin
            ldk = 1'b1;
            slot_n = slot + 2'd1;
            fire = slot == 2'd3;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HUNT;
         slot <= 2'd0;
         h0 <= '0;
         h1 <= '0;
         h2 <= '0;
         out_a <= '0;
         out_b <= '0;
         out_c <= '0;
         out_d <= '0;
         out_valid <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         state <= state_n;
         slot <= slot_n;
         out_valid <= fire;
         sync_err <= err_n;
         if (ld0) h0 <= in_data;
         if (ldk && slot == 2'd1) h1 <= in_data;
         if (ldk && slot == 2'd2) h2 <= in_data;
         // the slot-3 word goes straight to out_d alongside the held slots
         if (fire) begin
            out_a <= h0;
            out_b <= h1;
            out_c <= h2;
            out_d <= in_data;
         end
      end
   end
   assign locked = state == LOCKED;
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb_tdm_demux_1x4: directed plus random frames checked against a queue-based frame model.
module tb_tdm_demux_1x4;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sync = 1'b0;
   logic [3:0] in_data = '0;
   logic [3:0] out_a, out_b, out_c, out_d;
   logic out_valid, sync_err, locked;
   logic [1:0] slot;
   int n_vec = 0, n_err = 0;
   logic [3:0] q[$];
   logic [3:0] e_out[4];
   bit m_lock, e_v, e_e;

   tdm_demux_1x4 #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sync(in_sync),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
      .out_valid(out_valid), .sync_err(sync_err), .locked(locked), .slot(slot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("out_a", 8'(out_a), 8'(e_out[0]));
      chk("out_b", 8'(out_b), 8'(e_out[1]));
      chk("out_c", 8'(out_c), 8'(e_out[2]));
      chk("out_d", 8'(out_d), 8'(e_out[3]));
      chk("out_valid", 8'(out_valid), 8'(e_v));
      chk("sync_err", 8'(sync_err), 8'(e_e));
      chk("locked", 8'(locked), 8'(m_lock));
      chk("slot", 8'(slot), 8'(q.size()));
   endtask

   task automatic model_reset();
      q = {};
      m_lock = 0;
      e_v = 0;
      e_e = 0;
      foreach (e_out[i]) e_out[i] = '0;
   endtask

   // frame-level view: q holds the words of the frame in progress
   task automatic model(input logic v, input logic s, input logic [3:0] d);
      e_v = 0;
      e_e = 0;
      if (v) begin
         if (!m_lock) begin
            if (s) begin q = {d}; m_lock = 1; end
         end else if (s) begin
            e_e = q.size() != 0;
            q = {d};
         end else if (q.size() == 0) begin
            e_e = 1;
            m_lock = 0;
         end else begin
            q.push_back(d);
            if (q.size() == 4) begin
               foreach (e_out[i]) e_out[i] = q[i];
               e_v = 1;
               q = {};
            end
         end
      end
   endtask

   task automatic step(input logic v, input logic s, input logic [3:0] d);
      in_valid = v;
      in_sync = s;
      in_data = d;
      @(posedge clk);
      model(v, s, d);
      #1 check_all();
      @(negedge clk);
   endtask

   task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      step(1, 1, a);
      step(1, 0, b);
      step(1, 0, c);
      step(1, 0, d);
   endtask

   initial begin
      model_reset();
      #1 check_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      // lock and single frame, sync presented in the reset-release cycle
      frame(4'h1, 4'h2, 4'h3, 4'h4);
      chk("frame1_a", 8'(out_a), 8'h1);
      chk("frame1_d", 8'(out_d), 8'h4);
      step(0, 0, 0);
      // hunt discard
      rst = 1'b1;
      #1 model_reset();
      check_all();
      rst = 1'b0;
      @(negedge clk);
      step(1, 0, 4'hA);
      step(1, 0, 4'hB);
      frame(4'h5, 4'h6, 4'h7, 4'h8);
      chk("hunt_c", 8'(out_c), 8'h7);
      // stalls within a frame
      step(1, 1, 4'h1);
      for (int i = 2; i <= 4; i++) begin
         repeat (3) step(0, 1, 4'hE);
         step(1, 0, 4'(i));
      end
      chk("stall_b", 8'(out_b), 8'h2);
      // early sync abandons partial 1,2
      step(1, 1, 4'h1);
      step(1, 0, 4'h2);
      frame(4'h9, 4'hA, 4'hB, 4'hC);
      chk("early_a", 8'(out_a), 8'h9);
      // missing sync drops lock, outputs hold, then relock
      step(1, 0, 4'hF);
      chk("miss_lock", 8'(locked), 8'h0);
      frame(4'hD, 4'hE, 4'hF, 4'h0);
      // async reset mid-frame
      step(1, 1, 4'h7);
      step(1, 0, 4'h8);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      #1 rst = 1'b0;
      @(negedge clk);
      frame(4'h4, 4'h3, 4'h2, 4'h1);
      chk("rst_d", 8'(out_d), 8'h1);
      // back-to-back then random traffic
      repeat (3) frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 4'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/tdm_demux_1x4.md
# tdm_demux_1x4

Four-slot time-division demultiplexer: receives a single framed word stream and distributes slots 0..3 to four parallel outputs a, b, c, d. It is the receive end of the 4:1 select path: slot order a, b, c, d matches select codes {s0,s1} = 00, 01, 10, 11. The block locks to a frame-sync marker and presents each complete frame on all four outputs simultaneously. Partial or misaligned frames are reported and never presented.

## Interface
- WIDTH, 1, bits per slot word
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_sync qualified this cycle
- in_data  input  WIDTH  slot word
- in_sync  input  1  marks the word as slot 0 (frame start); ignored when in_valid=0
- out_a, out_b, out_c, out_d  output  WIDTH  frame words, slots 0..3, registered
- out_valid  output  1  one-cycle pulse: new frame on out_a..out_d
- sync_err  output  1  one-cycle pulse: framing error detected
- locked  output  1  FSM in LOCKED
- slot  output  2  index of the next expected slot, {s0,s1}

## Operation
- Accepted word = in_valid=1 at a rising edge. With in_valid=0, no state changes, and in_sync is don't-care.
- FSM states:
  - HUNT (reset state):
    - Accepted word with in_sync=0 is discarded.
    - Accepted word with in_sync=1 is captured as slot 0, slot becomes 1, and the FSM goes to LOCKED.
  - LOCKED:
    - slot=0, in_sync=1: capture slot 0, slot becomes 1.
    - slot=0, in_sync=0: sync_err pulse, word discarded, go to HUNT, slot=0.
    - slot=1..3, in_sync=0: capture into holding register [slot], slot increments.
    - slot=1..3, in_sync=1: sync_err pulse, partial frame discarded. The word is captured as slot 0 of a new frame, slot becomes 1, and the FSM stays LOCKED.
    - Slot 3 accepted: out_a..out_d load holding regs 0..2 plus the slot-3 word, out_valid pulses, and slot wraps to 0.
- Output registers change only on frame completion; otherwise they hold the previous frame.
- Holding registers are internal only. Discarded partial frames never reach the outputs.
- locked=1 exactly while the FSM is in LOCKED.

## Timing
- Reset (asynchronous, immediate):
  - out_a..out_d=0, out_valid=0, sync_err=0, locked=0, slot=0, FSM=HUNT.
  - Holding registers=0.
- Reset mid-frame discards the partial frame; no out_valid is produced.
- Latency: out_valid and the new out_a..out_d appear the cycle after the edge accepting slot 3, registered together.
- Back-to-back frames, in_valid continuously high: out_valid pulses once every 4 cycles, with no bubble between frames.
- sync_err is registered and asserts the cycle after the offending acceptance. It never coincides with out_valid for the same frame.
- Stalls (in_valid=0) anywhere within a frame are allowed with no limit, and do not break lock.
- First in_sync after reset: in_sync=1 with in_valid=1 in the same cycle as rst deassertion is accepted at the next rising edge.

## Test plan
- Lock and single frame:
  - Stimulus: reset; accept sync+0x1, then 0x2, 0x3, 0x4 (WIDTH=4) on 4 consecutive cycles.
  - Required: after 4th edge, out_a..d = 1,2,3,4, out_valid high 1 cycle, locked=1, slot=0.
- Hunt discard:
  - Stimulus: after reset, accept 0xA, 0xB without sync, then a full frame sync+5,6,7,8.
  - Required: no out_valid before the frame; out = 5,6,7,8; sync_err never asserted.
- Stalls:
  - Stimulus: frame 1,2,3,4 with in_valid low for 3 cycles between each word.
  - Required: single out_valid after the word 4 edge; outputs 1,2,3,4; the held previous frame is unchanged before that.
- Early sync:
  - Stimulus: locked; accept sync+1, 2, then sync+9, A, B, C.
  - Required: sync_err pulse after the second sync; a single out_valid with outputs 9,A,B,C; partial 1,2 never output.
- Missing sync:
  - Stimulus: locked; after a full frame, accept 0xF without sync.
  - Required: sync_err pulse, locked=0, outputs keep the prior frame, and the next sync frame relocks.
- Async reset mid-frame:
  - Stimulus: after slots 0..1, assert rst between edges.
  - Required: all outputs 0 immediately, locked=0; a following frame 4,3,2,1 outputs correctly.
